// File: rtl/wb_majority_voter.sv
// N-channel writeback voter: gathers one {we, addr, data} beat per redundant core,
// waits a bounded time for stragglers, then registers the majority beat and fault status.
module wb_majority_voter #(
  parameter int NUM_CH        = 3,
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              valid_i,
  output logic [NUM_CH-1:0]              ready_o,
  input  logic [NUM_CH-1:0]              we_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   data_i,
  output logic                           valid_o,
  output logic                           we_o,
  output logic [ADDR_WIDTH-1:0]          addr_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           error_o,
  output logic [NUM_CH-1:0]              faulty_ch_o,
  output logic                           fatal_o,
  output logic [ERR_CNT_WIDTH-1:0]       err_cnt_o,
  input  logic                           clear_i
);

  localparam int TW  = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CW  = $clog2(NUM_CH + 1);
  localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [NUM_CH-1:0] flag_r, flag_s;
  logic [NUM_CH-1:0] ready_r, ready_s;
  logic [NUM_CH-1:0] cap_s;
  logic [TMW-1:0]    tmo_r, tmo_s;
  logic              vote_s;
  logic [TW-1:0]     tup_r    [NUM_CH];
  logic [TW-1:0]     in_tup_s [NUM_CH];
  logic              maj_s;
  logic [TW-1:0]     maj_tup_s;
  logic [NUM_CH-1:0] faulty_s;
  logic              err_s;

  function automatic logic tup_eq(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return (a == b);
  endfunction

  // Pack each channel's beat into a single comparable tuple.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      in_tup_s[c] = {we_i[c], addr_i[c*ADDR_WIDTH +: ADDR_WIDTH], data_i[c*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  assign cap_s   = valid_i & ready_r;
  assign ready_o = ready_r;

  // Next-state, capture flags and skew timer.
  always_comb begin
    state_s = state_r;
    tmo_s   = tmo_r;
    flag_s  = flag_r | cap_s;
    vote_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (&flag_s) begin
          state_s = ST_VOTE;
        end else if (|cap_s) begin
          state_s = ST_COLLECT;
          tmo_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (&flag_s) begin
          state_s = ST_VOTE;
        end else if (tmo_r == TMW'(TIMEOUT - 1)) begin
          state_s = ST_VOTE;
        end else begin
          tmo_s = tmo_r + TMW'(1);
        end
      end
      ST_VOTE: begin
        state_s = ST_IDLE;
        flag_s  = '0;
        vote_s  = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
        flag_s  = '0;
      end
    endcase
    // Late channels are not accepted during the vote cycle, so no beat is silently dropped.
    if (state_s == ST_VOTE) begin
      ready_s = '0;
    end else begin
      ready_s = ~flag_s;
    end
  end

  // FSM state, flags, timer and handshake registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      flag_r  <= '0;
      ready_r <= '1;
      tmo_r   <= '0;
    end else begin
      state_r <= state_s;
      flag_r  <= flag_s;
      ready_r <= ready_s;
      tmo_r   <= tmo_s;
    end
  end

  // Per-channel beat capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        tup_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_s[c]) begin
          tup_r[c] <= in_tup_s[c];
        end
      end
    end
  end

  // Majority search; the threshold is over all channels, not only those present.
  always_comb begin
    logic [CW-1:0] cnt;
    cnt       = '0;
    maj_s     = 1'b0;
    maj_tup_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt = '0;
      for (int j = 0; j < NUM_CH; j++) begin
        if (flag_r[j] && tup_eq(tup_r[j], tup_r[i])) begin
          cnt = cnt + CW'(1);
        end else begin
          cnt = cnt;
        end
      end
      if (flag_r[i] && !maj_s && (cnt > CW'(NUM_CH / 2))) begin
        maj_s     = 1'b1;
        maj_tup_s = tup_r[i];
      end else begin
        maj_s     = maj_s;
      end
    end
  end

  // Fault mask and error condition for the current vote.
  always_comb begin
    faulty_s = '1;
    if (maj_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        faulty_s[c] = ~flag_r[c] | ~tup_eq(tup_r[c], maj_tup_s);
      end
    end else begin
      faulty_s = '1;
    end
    err_s = ~maj_s | (|faulty_s);
  end

  // Registered voted beat, pulses and held fault mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o     <= 1'b0;
      error_o     <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      faulty_ch_o <= '0;
    end else begin
      valid_o <= 1'b0;
      error_o <= 1'b0;
      if (vote_s) begin
        valid_o     <= maj_s;
        error_o     <= err_s;
        faulty_ch_o <= faulty_s;
        if (maj_s) begin
          {we_o, addr_o, data_o} <= maj_tup_s;
        end
      end
    end
  end

  // Sticky fatal flag and saturating error counter; clear dominates a coincident vote.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fatal_o   <= 1'b0;
      err_cnt_o <= '0;
    end else if (clear_i) begin
      fatal_o   <= 1'b0;
      err_cnt_o <= '0;
    end else if (vote_s) begin
      if (err_s && !(&err_cnt_o)) begin
        err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
      end
      if (!maj_s) begin
        fatal_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_majority_voter.sv
// Directed bench for wb_majority_voter: a transaction-level vote model checked every cycle
// on a 3-channel instance, plus literal checks on a 2-channel instance.
module tb_wb_majority_voter;

  localparam int NC = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int EW = 2;
  localparam int TW = 1 + AW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 3-channel DUT
  logic [NC-1:0]    valid = '0, we = '0, ready, faulty;
  logic [NC*AW-1:0] addr = '0;
  logic [NC*DW-1:0] data = '0;
  logic             clear = 1'b0;
  logic             valid_o, we_o, error_o, fatal;
  logic [AW-1:0]    addr_o;
  logic [DW-1:0]    data_o;
  logic [EW-1:0]    cnt;

  wb_majority_voter #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .ERR_CNT_WIDTH(EW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready), .we_i(we), .addr_i(addr),
    .data_i(data), .valid_o(valid_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
    .error_o(error_o), .faulty_ch_o(faulty), .fatal_o(fatal), .err_cnt_o(cnt), .clear_i(clear));

  // 2-channel DUT
  logic [1:0]    valid2 = '0, we2 = '0, ready2, faulty2;
  logic [2*AW-1:0] addr2 = '0;
  logic [2*DW-1:0] data2 = '0;
  logic          clear2 = 1'b0;
  logic          valid2_o, we2_o, error2_o, fatal2;
  logic [AW-1:0] addr2_o;
  logic [DW-1:0] data2_o;
  logic [7:0]    cnt2;

  wb_majority_voter #(.NUM_CH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .ERR_CNT_WIDTH(8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid2), .ready_o(ready2), .we_i(we2), .addr_i(addr2),
    .data_i(data2), .valid_o(valid2_o), .we_o(we2_o), .addr_o(addr2_o), .data_o(data2_o),
    .error_o(error2_o), .faulty_ch_o(faulty2), .fatal_o(fatal2), .err_cnt_o(cnt2), .clear_i(clear2));

  // Expected outcome of the pending vote and the model's view of the held outputs
  int            exp_out_cyc = -1;
  int            exp_clr_cyc = -1;
  bit            exp_valid = 0, exp_err = 0, exp_clr = 0;
  logic [TW-1:0] exp_tup = '0;
  logic [NC-1:0] exp_faulty = '0;
  logic          m_we = 0, m_fatal = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [NC-1:0] m_faulty = '0;
  int            m_cnt = 0;

  always @(negedge clk) begin
    if (cyc == exp_out_cyc) begin
      if (exp_valid) {m_we, m_addr, m_data} = exp_tup;
      m_faulty = exp_faulty;
      if (exp_clr) begin
        m_cnt = 0;
        m_fatal = 0;
      end else begin
        if (exp_err && m_cnt < (1 << EW) - 1) m_cnt++;
        if (!exp_valid) m_fatal = 1;
      end
    end
    if (cyc == exp_clr_cyc) begin
      m_cnt = 0;
      m_fatal = 0;
    end
    chk("valid_o", valid_o, (cyc == exp_out_cyc) && exp_valid);
    chk("error_o", error_o, (cyc == exp_out_cyc) && exp_err);
    chk("we_o", we_o, m_we);
    chk("addr_o", addr_o, m_addr);
    chk("data_o", data_o, m_data);
    chk("faulty_ch_o", faulty, m_faulty);
    chk("fatal_o", fatal, m_fatal);
    chk("err_cnt_o", cnt, m_cnt);
  end

  function automatic logic [TW-1:0] mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {w, a, d};
  endfunction

  // Drive one beat per channel; d[c] is the arrival cycle offset, -1 means the channel never shows up.
  task automatic beat(input logic [TW-1:0] t0, t1, t2, input int d0, d1, d2, input bit clr);
    logic [TW-1:0] t [NC];
    int            d [NC];
    bit            capd [NC];
    int            maxd, v, n, base;
    bit            all_in, found;
    logic [TW-1:0] mt;
    logic [NC-1:0] f;
    t[0] = t0; t[1] = t1; t[2] = t2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    @(posedge clk); #1;
    base = cyc;
    maxd = 0; all_in = 1;
    for (int c = 0; c < NC; c++) begin
      capd[c] = (d[c] >= 0) && (d[c] <= TO);
      if (!capd[c]) all_in = 0;
      else if (d[c] > maxd) maxd = d[c];
    end
    v = all_in ? maxd + 1 : TO + 1;
    found = 0; mt = '0;
    for (int i = 0; i < NC; i++) begin
      n = 0;
      for (int j = 0; j < NC; j++) if (capd[i] && capd[j] && t[j] == t[i]) n++;
      if (!found && n > NC / 2) begin
        found = 1;
        mt = t[i];
      end
    end
    for (int c = 0; c < NC; c++) f[c] = found ? (!capd[c] || t[c] != mt) : 1'b1;
    exp_valid = found; exp_tup = mt; exp_faulty = f; exp_err = !found || (|f); exp_clr = clr;
    exp_out_cyc = base + v + 1;
    for (int r = 0; r <= v; r++) begin
      for (int c = 0; c < NC; c++) begin
        valid[c] = (d[c] == r);
        we[c] = t[c][TW-1];
        addr[c*AW +: AW] = t[c][DW +: AW];
        data[c*DW +: DW] = t[c][DW-1:0];
      end
      clear = clr && (r == v);
      @(posedge clk); #1;
    end
    valid = '0;
    clear = 1'b0;
    chk("ready_after_vote", ready, 3'b111);
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1;
    clear = 1'b1;
    exp_clr_cyc = cyc + 1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  localparam logic [DW-1:0] GOOD = 32'hDEADBEEF;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 3'b111);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_cnt", cnt, 2'd0);
    chk("rst_ready2", ready2, 2'b11);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // unanimous beat: 2-cycle latency, no error
    beat(mk(1'b1, 5'h03, GOOD), mk(1'b1, 5'h03, GOOD), mk(1'b1, 5'h03, GOOD), 0, 0, 0, 1'b0);
    chk("t1_data", data_o, GOOD);
    chk("t1_addr", addr_o, 5'h03);
    chk("t1_faulty", faulty, 3'b000);
    chk("t1_cnt", cnt, 2'd0);

    // single corrupted channel is outvoted
    beat(mk(1'b1, 5'h03, GOOD), mk(1'b1, 5'h03, 32'hDEADBEEE), mk(1'b1, 5'h03, GOOD), 0, 0, 0, 1'b0);
    chk("t2_data", data_o, GOOD);
    chk("t2_faulty", faulty, 3'b010);
    chk("t2_cnt", cnt, 2'd1);

    // skewed arrival with a missing channel resolved by timeout
    beat(mk(1'b0, 5'h0A, 32'h12345678), mk(1'b0, 5'h00, 32'h0), mk(1'b0, 5'h0A, 32'h12345678), 0, -1, 2, 1'b0);
    chk("t3_faulty", faulty, 3'b010);
    chk("t3_addr", addr_o, 5'h0A);
    chk("t3_cnt", cnt, 2'd2);

    // faulty vote coinciding with clear
    beat(mk(1'b1, 5'h1F, 32'h0), mk(1'b1, 5'h1F, 32'h0), mk(1'b0, 5'h1F, 32'h0), 0, 1, 0, 1'b1);
    chk("t4_cnt", cnt, 2'd0);
    chk("t4_faulty", faulty, 3'b100);

    // three-way disagreement: no majority, data held, fatal sticky
    beat(mk(1'b1, 5'h01, 32'h1), mk(1'b1, 5'h02, 32'h1), mk(1'b1, 5'h03, 32'h1), 0, 0, 0, 1'b0);
    chk("t5_fatal", fatal, 1'b1);
    chk("t5_data_held", data_o, 32'h0);
    chk("t5_faulty", faulty, 3'b111);

    // five more faulty votes saturate the 2-bit counter
    for (int k = 0; k < 5; k++)
      beat(mk(1'b1, 5'h04, GOOD), mk(1'b1, 5'h04, GOOD), mk(1'b1, 5'h05, GOOD), 0, 0, 0, 1'b0);
    chk("t6_cnt_sat", cnt, 2'd3);
    chk("t6_fatal_held", fatal, 1'b1);
    chk("t6_data", data_o, GOOD);

    clear_pulse();
    @(posedge clk); #1;
    chk("clr_cnt", cnt, 2'd0);
    chk("clr_fatal", fatal, 1'b0);

    // reset while collecting: the partial beat disappears
    @(posedge clk); #1;
    valid = 3'b001;
    we = 3'b111;
    @(posedge clk); #1;
    valid = '0;
    chk("coll_ready", ready, 3'b110);
    rst_n = 1'b0;
    exp_out_cyc = -1;
    m_we = 0; m_addr = '0; m_data = '0; m_faulty = '0; m_fatal = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstc_ready", ready, 3'b111);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rstc_ready_after", ready, 3'b111);

    // 2-channel: any difference is fatal
    valid2 = 2'b11; we2 = 2'b11;
    addr2 = {5'h02, 5'h01};
    data2 = {GOOD, GOOD};
    @(posedge clk); #1;
    valid2 = 2'b00;
    @(posedge clk); #1;
    chk("c2_valid", valid2_o, 1'b0);
    chk("c2_error", error2_o, 1'b1);
    chk("c2_fatal", fatal2, 1'b1);
    chk("c2_faulty", faulty2, 2'b11);
    chk("c2_cnt", cnt2, 8'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("c2_fatal_held", fatal2, 1'b1);
    clear2 = 1'b1;
    @(posedge clk); #1;
    clear2 = 1'b0;
    chk("c2_clr_fatal", fatal2, 1'b0);
    chk("c2_clr_cnt", cnt2, 8'd0);
    valid2 = 2'b11;
    addr2 = {5'h07, 5'h07};
    @(posedge clk); #1;
    valid2 = 2'b00;
    @(posedge clk); #1;
    chk("c2_agree_valid", valid2_o, 1'b1);
    chk("c2_agree_error", error2_o, 1'b0);
    chk("c2_agree_addr", addr2_o, 5'h07);
    chk("c2_agree_faulty", faulty2, 2'b00);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
